// File: rtl/top_module_looper_if.sv
// Group-allocation, branch commit/recovery and status bundle for the looper.
interface top_module_looper_if;
    // Requests into the looper
    logic        flush_cache;
    logic [15:0] extern_pc;
    logic        extern_pc_en;
    logic        alloc_vld;
    logic [3:0]  brch;
    logic        cmt_brch;
    logic [5:0]  cmt_brch_indx;
    logic        mis_pred;
    logic [5:0]  brch_mis_indx;
    logic [15:0] rcvr_pc;

    // Looper state and status
    logic [15:0] pc;
    logic [5:0]  nxt_indx;
    logic [6:0]  curr_pos;
    logic [1:0]  brnc_count;
    logic        head;
    logic        tail;
    logic [12:0] fifo0;
    logic [12:0] fifo1;
    logic        full;
    logic        empty;
    logic        stall;
    logic        halted;

    modport master (
        output flush_cache, extern_pc, extern_pc_en, alloc_vld, brch,
               cmt_brch, cmt_brch_indx, mis_pred, brch_mis_indx, rcvr_pc,
        input  pc, nxt_indx, curr_pos, brnc_count, head, tail,
               fifo0, fifo1, full, empty, stall, halted
    );

    modport slave (
        input  flush_cache, extern_pc, extern_pc_en, alloc_vld, brch,
               cmt_brch, cmt_brch_indx, mis_pred, brch_mis_indx, rcvr_pc,
        output pc, nxt_indx, curr_pos, brnc_count, head, tail,
               fifo0, fifo1, full, empty, stall, halted
    );
endinterface

// File: rtl/top_module_looper.sv
// Fetch looper: allocates 4-instruction groups, checkpoints up to two
// branches in a small FIFO and restores counters on a mispredict.
module top_module_looper (
    input  logic               clk,
    input  logic               rst_n,
    top_module_looper_if.slave bus
);
    localparam int unsigned PC_W  = 16;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned POS_W = 7;
    localparam int unsigned ENT_W = IDX_W + POS_W;
    localparam int unsigned GRP_N = 4;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [IDX_W-1:0] nxt_indx_q, nxt_indx_d;
    logic [POS_W-1:0] curr_pos_q, curr_pos_d;
    logic [ENT_W-1:0] fifo_q [2];
    logic [ENT_W-1:0] fifo_d [2];
    logic [1:0]       occ_q, occ_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic             halted_q, halted_d;

    logic [2:0]       popcnt_c;
    logic [1:0]       brnc_count_c;
    logic [1:0]       free_c;
    logic             stall_c;
    logic             accept_c;
    logic             pop_c;
    logic             young_c;
    logic [IDX_W-1:0] ent_idx_c;
    logic [POS_W-1:0] ent_pos_c;
    logic             slot0_vld_c;
    logic             slot1_vld_c;
    logic             unused_cmt_indx;

    // The committing index is trusted, never compared
    assign unused_cmt_indx = ^bus.cmt_brch_indx;

    // Branch count of the presented group and the allocate/stall decision
    always_comb begin
        popcnt_c     = 3'(bus.brch[0]) + 3'(bus.brch[1]) + 3'(bus.brch[2]) + 3'(bus.brch[3]);
        brnc_count_c = 2'd0;
        if (bus.alloc_vld) begin
            brnc_count_c = (popcnt_c > 3'd2) ? 2'd3 : popcnt_c[1:0];
        end
        free_c   = 2'd2 - occ_q;
        stall_c  = bus.alloc_vld && ((brnc_count_c > free_c) || halted_q ||
                                     bus.mis_pred || bus.extern_pc_en);
        accept_c = bus.alloc_vld && !stall_c;
    end

    // Next state: commit first, then allocation or mispredict recovery, then PC
    always_comb begin
        pc_d       = pc_q;
        nxt_indx_d = nxt_indx_q;
        curr_pos_d = curr_pos_q;
        fifo_d     = fifo_q;
        halted_d   = halted_q | bus.flush_cache;
        ent_idx_c  = '0;
        ent_pos_c  = '0;

        pop_c   = bus.cmt_brch && (occ_q != 2'd0);
        head_d  = head_q ^ pop_c;
        occ_d   = occ_q - 2'(pop_c);
        tail_d  = tail_q;
        young_c = ~head_d;

        if (accept_c) begin
            for (int unsigned k = 0; k < GRP_N; k++) begin
                if (bus.brch[k]) begin
                    ent_idx_c      = nxt_indx_q + IDX_W'(k);
                    ent_pos_c      = curr_pos_q + POS_W'(k);
                    fifo_d[tail_d] = {ent_idx_c, ent_pos_c};
                    tail_d         = ~tail_d;
                    occ_d          = occ_d + 2'd1;
                end
            end
            nxt_indx_d = nxt_indx_q + IDX_W'(GRP_N);
            curr_pos_d = curr_pos_q + POS_W'(GRP_N);
        end

        // Mispredict never coincides with an accepted group (it stalls it)
        if (bus.mis_pred) begin
            if ((occ_d != 2'd0) && (fifo_q[head_d][ENT_W-1:POS_W] == bus.brch_mis_indx)) begin
                tail_d     = head_d;
                occ_d      = 2'd0;
                nxt_indx_d = fifo_q[head_d][ENT_W-1:POS_W] + IDX_W'(1);
                curr_pos_d = fifo_q[head_d][POS_W-1:0] + POS_W'(1);
            end else if ((occ_d == 2'd2) && (fifo_q[young_c][ENT_W-1:POS_W] == bus.brch_mis_indx)) begin
                tail_d     = young_c;
                occ_d      = 2'd1;
                nxt_indx_d = fifo_q[young_c][ENT_W-1:POS_W] + IDX_W'(1);
                curr_pos_d = fifo_q[young_c][POS_W-1:0] + POS_W'(1);
            end else begin
                tail_d = head_d;
                occ_d  = 2'd0;
            end
        end

        if (bus.extern_pc_en) begin
            pc_d = bus.extern_pc;
        end else if (!halted_q) begin
            if (bus.mis_pred) begin
                pc_d = bus.rcvr_pc;
            end else if (accept_c) begin
                pc_d = pc_q + PC_W'(GRP_N);
            end
        end
    end

    // State registers, cleared asynchronously while rst_n is high
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q       <= '0;
            nxt_indx_q <= '0;
            curr_pos_q <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            occ_q      <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            nxt_indx_q <= nxt_indx_d;
            curr_pos_q <= curr_pos_d;
            fifo_q[0]  <= fifo_d[0];
            fifo_q[1]  <= fifo_d[1];
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            halted_q   <= halted_d;
        end
    end

    // Physical slots read as zero unless they hold a live checkpoint
    always_comb begin
        slot0_vld_c = (occ_q == 2'd2) || ((occ_q == 2'd1) && !head_q);
        slot1_vld_c = (occ_q == 2'd2) || ((occ_q == 2'd1) && head_q);
    end

    assign bus.pc         = pc_q;
    assign bus.nxt_indx   = nxt_indx_q;
    assign bus.curr_pos   = curr_pos_q;
    assign bus.brnc_count = brnc_count_c;
    assign bus.head       = head_q;
    assign bus.tail       = tail_q;
    assign bus.fifo0      = slot0_vld_c ? fifo_q[0] : '0;
    assign bus.fifo1      = slot1_vld_c ? fifo_q[1] : '0;
    assign bus.full       = (occ_q == 2'd2);
    assign bus.empty      = (occ_q == 2'd0);
    assign bus.stall      = stall_c;
    assign bus.halted     = halted_q;
endmodule

// File: tb/tb_top_module_looper.sv
// Randomized scoreboard bench for the fetch looper.
module tb_top_module_looper;
    logic clk = 1'b0;
    logic rst_n;

    top_module_looper_if bus ();

    top_module_looper dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        flush;
        bit [15:0] epc;
        bit        epc_en;
        bit        alloc;
        bit [3:0]  brch;
        bit        cmt;
        bit [5:0]  cidx;
        bit        mis;
        bit [5:0]  midx;
        bit [15:0] rpc;
    } stim_t;

    typedef struct {
        int pc, nxt, pos, brnc, head, tail, fifo0, fifo1, full, empty, stall, halted;
    } exp_t;

    typedef struct packed {
        logic [5:0] idx;
        logic [6:0] pos;
    } ent_t;

    // Reference model: ordered list of live checkpoints, oldest first
    int   m_pc, m_nxt, m_pos, m_head;
    bit   m_halted;
    ent_t m_fq[$];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    function automatic void m_reset();
        m_pc = 0; m_nxt = 0; m_pos = 0; m_head = 0; m_halted = 0;
        m_fq.delete();
    endfunction

    function automatic void m_comb(input stim_t s, output int brnc, output bit stall);
        int cnt;
        cnt   = $countones(s.brch);
        brnc  = s.alloc ? ((cnt > 2) ? 3 : cnt) : 0;
        stall = s.alloc && ((brnc > (2 - m_fq.size())) || m_halted || s.mis || s.epc_en);
    endfunction

    function automatic exp_t m_expect(input stim_t s);
        exp_t e;
        int   brnc;
        bit   stall;
        int   slot;
        m_comb(s, brnc, stall);
        e.pc = m_pc; e.nxt = m_nxt; e.pos = m_pos; e.brnc = brnc;
        e.head = m_head; e.tail = (m_head + m_fq.size()) % 2;
        e.fifo0 = 0; e.fifo1 = 0;
        for (int i = 0; i < m_fq.size(); i++) begin
            slot = (m_head + i) % 2;
            if (slot == 0) e.fifo0 = int'(m_fq[i].idx) * 128 + int'(m_fq[i].pos);
            else           e.fifo1 = int'(m_fq[i].idx) * 128 + int'(m_fq[i].pos);
        end
        e.full = (m_fq.size() == 2) ? 1 : 0;
        e.empty = (m_fq.size() == 0) ? 1 : 0;
        e.stall = stall ? 1 : 0;
        e.halted = m_halted ? 1 : 0;
        return e;
    endfunction

    function automatic void m_next(input stim_t s);
        int   brnc;
        bit   stall;
        bit   acc;
        int   hit;
        ent_t e;
        if (s.rst) begin
            m_reset();
            return;
        end
        m_comb(s, brnc, stall);
        acc = s.alloc && !stall;
        if (s.epc_en)           m_pc = s.epc;
        else if (!m_halted) begin
            if (s.mis)          m_pc = s.rpc;
            else if (acc)       m_pc = (m_pc + 4) % 65536;
        end
        if (s.cmt && m_fq.size() > 0) begin
            void'(m_fq.pop_front());
            m_head = 1 - m_head;
        end
        if (acc) begin
            for (int k = 0; k < 4; k++) begin
                if (s.brch[k]) begin
                    e.idx = 6'((m_nxt + k) % 64);
                    e.pos = 7'((m_pos + k) % 128);
                    m_fq.push_back(e);
                end
            end
            m_nxt = (m_nxt + 4) % 64;
            m_pos = (m_pos + 4) % 128;
        end
        if (s.mis) begin
            hit = -1;
            for (int i = 0; i < m_fq.size(); i++) begin
                if (hit < 0 && m_fq[i].idx == s.midx) hit = i;
            end
            if (hit >= 0) begin
                m_nxt = (int'(m_fq[hit].idx) + 1) % 64;
                m_pos = (int'(m_fq[hit].pos) + 1) % 128;
                while (m_fq.size() > hit) void'(m_fq.pop_back());
            end else begin
                m_fq.delete();
            end
        end
        if (s.flush) m_halted = 1;
    endfunction

    function automatic stim_t idle_s();
        stim_t s;
        s.rst = 0; s.flush = 0; s.epc = 0; s.epc_en = 0; s.alloc = 0; s.brch = 0;
        s.cmt = 0; s.cidx = 0; s.mis = 0; s.midx = 0; s.rpc = 0;
        return s;
    endfunction

    function automatic stim_t rand_s();
        stim_t s;
        s        = idle_s();
        s.rst    = ($urandom_range(0, 99) < 1);
        s.flush  = ($urandom_range(0, 999) < 3);
        s.epc_en = ($urandom_range(0, 99) < 3);
        s.epc    = 16'($urandom);
        s.alloc  = ($urandom_range(0, 99) < 60);
        s.brch   = 4'($urandom) & 4'($urandom);
        s.cmt    = ($urandom_range(0, 99) < 30);
        s.cidx   = 6'($urandom);
        s.mis    = ($urandom_range(0, 99) < 8);
        if (m_fq.size() > 0 && $urandom_range(0, 99) < 70)
            s.midx = m_fq[$urandom_range(0, m_fq.size() - 1)].idx;
        else
            s.midx = 6'($urandom);
        s.rpc    = 16'($urandom);
        return s;
    endfunction

    // One cycle: drive after the edge, record what the DUT must show, advance model
    task automatic step(input stim_t s);
        @(posedge clk);
        #1;
        rst_n             = s.rst;
        bus.flush_cache   = s.flush;
        bus.extern_pc     = s.epc;
        bus.extern_pc_en  = s.epc_en;
        bus.alloc_vld     = s.alloc;
        bus.brch          = s.brch;
        bus.cmt_brch      = s.cmt;
        bus.cmt_brch_indx = s.cidx;
        bus.mis_pred      = s.mis;
        bus.brch_mis_indx = s.midx;
        bus.rcvr_pc       = s.rpc;
        if (s.rst) m_reset();
        exp_q.push_back(m_expect(s));
        m_next(s);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",         int'(bus.pc),         e.pc);
                chk("nxt_indx",   int'(bus.nxt_indx),   e.nxt);
                chk("curr_pos",   int'(bus.curr_pos),   e.pos);
                chk("brnc_count", int'(bus.brnc_count), e.brnc);
                chk("head",       int'(bus.head),       e.head);
                chk("tail",       int'(bus.tail),       e.tail);
                chk("fifo0",      int'(bus.fifo0),      e.fifo0);
                chk("fifo1",      int'(bus.fifo1),      e.fifo1);
                chk("full",       int'(bus.full),       e.full);
                chk("empty",      int'(bus.empty),      e.empty);
                chk("stall",      int'(bus.stall),      e.stall);
                chk("halted",     int'(bus.halted),     e.halted);
            end
        end
    end

    // Stimulus: directed scenarios with fixed expectations, then random traffic
    initial begin
        stim_t r;
        stim_t a;
        m_reset();
        r = idle_s();
        r.rst = 1;
        rst_n = 1'b1;
        bus.flush_cache = 0; bus.extern_pc = 0; bus.extern_pc_en = 0; bus.alloc_vld = 0;
        bus.brch = 0; bus.cmt_brch = 0; bus.cmt_brch_indx = 0; bus.mis_pred = 0;
        bus.brch_mis_indx = 0; bus.rcvr_pc = 0;

        // Three branch-free groups
        step(r);
        settle();
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_fifo1", int'(bus.fifo1), 0);
        a = idle_s(); a.alloc = 1;
        repeat (3) step(a);
        step(idle_s());
        settle();
        chk("d28_pc", int'(bus.pc), 12);
        chk("d28_nxt", int'(bus.nxt_indx), 12);
        chk("d28_pos", int'(bus.curr_pos), 12);
        chk("d28_empty", int'(bus.empty), 1);

        // Two checkpoints fill the FIFO, then commit and mispredict
        step(r);
        a = idle_s(); a.alloc = 1; a.brch = 4'b0101;
        step(a);
        a.brch = 4'b0001;
        step(a);
        settle();
        chk("d29_fifo0", int'(bus.fifo0), 0);
        chk("d29_fifo1", int'(bus.fifo1), 258);
        chk("d29_full", int'(bus.full), 1);
        chk("d29_stall", int'(bus.stall), 1);
        chk("d29_pc", int'(bus.pc), 4);
        a = idle_s(); a.cmt = 1;
        step(a);
        a = idle_s(); a.mis = 1; a.midx = 6'd2; a.rpc = 16'h0040;
        step(a);
        settle();
        chk("d30_head", int'(bus.head), 1);
        chk("d30_full", int'(bus.full), 0);
        step(idle_s());
        settle();
        chk("d30_pc", int'(bus.pc), 16'h0040);
        chk("d30_nxt", int'(bus.nxt_indx), 3);
        chk("d30_pos", int'(bus.curr_pos), 3);
        chk("d30_empty", int'(bus.empty), 1);

        // External PC beats a mispredict
        a = idle_s(); a.epc_en = 1; a.epc = 16'h1234; a.mis = 1; a.midx = 6'd63; a.rpc = 16'h5555;
        step(a);
        step(idle_s());
        settle();
        chk("d31_pc", int'(bus.pc), 16'h1234);

        // Halt then reset
        step(r);
        a = idle_s(); a.flush = 1;
        step(a);
        a = idle_s(); a.alloc = 1;
        step(a);
        step(a);
        settle();
        chk("d32_halted", int'(bus.halted), 1);
        chk("d32_stall", int'(bus.stall), 1);
        chk("d32_pc", int'(bus.pc), 0);
        a.rst = 1;
        step(a);
        settle();
        chk("d32_rst_halted", int'(bus.halted), 0);
        chk("d32_rst_pc", int'(bus.pc), 0);

        // Index counter wrap
        step(r);
        a = idle_s(); a.alloc = 1;
        repeat (16) step(a);
        step(idle_s());
        settle();
        chk("d33_nxt", int'(bus.nxt_indx), 0);
        chk("d33_pos", int'(bus.curr_pos), 64);
        chk("d33_pc", int'(bus.pc), 64);

        repeat (4000) step(rand_s());
        step(idle_s());
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
